// File: rtl/pipe_stage_gen.sv
// Two-register scale/round/saturate pipeline across LANES signed lanes. A stall freezes everything.
// Each beat carries a stage tag and a boundary bit, and finished_o marks the close of a full pass.
module pipe_stage_gen #(
    parameter int LANES   = 4,
    parameter int DW      = 16,
    parameter int SW      = 16,
    parameter int NSTAGES = 4,
    parameter int MODE_W  = 2
) (
    input  logic                         CLK_i,
    input  logic                         RST_i,
    input  logic                         stall_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         stage_boundary_i,
    input  logic [LANES*DW-1:0]          operand_i,
    input  logic [SW-1:0]                scale_i,
    input  logic [$clog2(DW+SW)-1:0]     norm_n_i,
    input  logic [$clog2(LANES)-1:0]     pos_i,
    input  logic [NSTAGES*MODE_W-1:0]    mode_table_i,
    output logic                         out_valid_o,
    output logic [LANES*DW-1:0]          operand1_o,
    output logic [DW-1:0]                operand2_o,
    output logic [$clog2(NSTAGES)-1:0]   stage_o,
    output logic [MODE_W-1:0]            mode_o,
    output logic                         finished_o
);

    localparam int PW  = DW + SW;
    localparam int NW  = $clog2(DW + SW);
    localparam int PSW = $clog2(LANES);
    localparam int TW  = $clog2(NSTAGES);
    localparam logic [TW-1:0]      LAST_STG = TW'(NSTAGES - 1);
    localparam logic signed [PW:0] SAT_MAX  = $signed({{(PW-DW+2){1'b0}}, {(DW-1){1'b1}}});
    localparam logic signed [PW:0] SAT_MIN  = ~SAT_MAX;

    // One guard bit above the product keeps the rounding add from overflowing.
    function automatic logic signed [PW:0] round_shift(input logic signed [PW-1:0] p,
                                                       input logic [NW-1:0] n);
        logic signed [PW:0] ext;
        logic signed [PW:0] half;
        ext  = {p[PW-1], p};
        half = $signed(({{PW{1'b0}}, 1'b1} << n) >> 1);
        return (ext + half) >>> n;
    endfunction

    function automatic logic signed [DW-1:0] saturate(input logic signed [PW:0] v);
        if (v > SAT_MAX)      return {1'b0, {(DW-1){1'b1}}};
        else if (v < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
        else                  return v[DW-1:0];
    endfunction

    logic                   w_accept;
    logic signed [PW-1:0]   w_prod [LANES];
    logic signed [DW-1:0]   w_res  [LANES];

    logic                   r_vld_p1;
    logic [TW-1:0]          r_cnt;
    logic signed [PW-1:0]   r_prod_p1 [LANES];
    logic [NW-1:0]          r_n_p1;
    logic [PSW-1:0]         r_pos_p1;
    logic [TW-1:0]          r_tag_p1;
    logic                   r_bnd_p1;

    logic                   r_vld_p2;
    logic signed [DW-1:0]   r_res_p2 [LANES];
    logic [DW-1:0]          r_op2_p2;
    logic [TW-1:0]          r_stage_p2;
    logic [MODE_W-1:0]      r_mode_p2;
    logic                   r_bnd_p2;

    assign in_ready_o = !stall_i;
    assign w_accept   = in_valid_i && !stall_i;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_prod[k] = $signed({{SW{operand_i[k*DW+DW-1]}}, operand_i[k*DW +: DW]})
                      * $signed({{DW{scale_i[SW-1]}}, scale_i});
        end
    end

    // ---- S1: product, per-beat shift/lane select, stage tag ----
    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            r_vld_p1 <= 1'b0;
            r_cnt    <= '0;
        end else if (!stall_i) begin
            r_vld_p1 <= in_valid_i;
            if (in_valid_i && stage_boundary_i)
                r_cnt <= (r_cnt == LAST_STG) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK_i) begin
        if (w_accept) begin
            for (int k = 0; k < LANES; k++) r_prod_p1[k] <= w_prod[k];
            r_n_p1   <= norm_n_i;
            r_pos_p1 <= pos_i;
            r_tag_p1 <= r_cnt;
            r_bnd_p1 <= stage_boundary_i;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) w_res[k] = saturate(round_shift(r_prod_p1[k], r_n_p1));
    end

    // ---- S2: rounded, saturated result; data only updates on real beats ----
    always_ff @(posedge CLK_i or negedge RST_i) begin
        if (!RST_i) begin
            r_vld_p2   <= 1'b0;
            for (int k = 0; k < LANES; k++) r_res_p2[k] <= '0;
            r_op2_p2   <= '0;
            r_stage_p2 <= '0;
            r_mode_p2  <= '0;
            r_bnd_p2   <= 1'b0;
        end else if (!stall_i) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                for (int k = 0; k < LANES; k++) r_res_p2[k] <= w_res[k];
                r_op2_p2   <= w_res[r_pos_p1];
                r_stage_p2 <= r_tag_p1;
                r_mode_p2  <= mode_table_i[r_tag_p1*MODE_W +: MODE_W];
                r_bnd_p2   <= r_bnd_p1;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_out
        assign operand1_o[g*DW +: DW] = r_res_p2[g];
    end

    assign out_valid_o = r_vld_p2;
    assign operand2_o  = r_op2_p2;
    assign stage_o     = r_stage_p2;
    assign mode_o      = r_mode_p2;
    assign finished_o  = r_vld_p2 && r_bnd_p2 && (r_stage_p2 == LAST_STG);

endmodule

// File: tb/tb_pipe_stage_gen.sv
// Directed bench for pipe_stage_gen: arithmetic corners, stage tagging, stall and async reset.
module tb_pipe_stage_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        in_valid;
    logic        in_ready;
    logic        bnd;
    logic [63:0] operand;
    logic [15:0] scale;
    logic [4:0]  norm_n;
    logic [1:0]  pos;
    logic [7:0]  mode_table;
    logic        out_valid;
    logic [63:0] operand1;
    logic [15:0] operand2;
    logic [1:0]  stage;
    logic [1:0]  mode;
    logic        finished;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] opnd;
        logic [15:0] scale;
        logic [4:0]  n;
        logic [1:0]  pos;
        logic        bnd;
        logic [63:0] e_op1;
        logic [15:0] e_op2;
        logic [1:0]  e_stg;
        logic [1:0]  e_mode;
        logic        e_fin;
    } vec_t;

    vec_t vq[$];

    pipe_stage_gen #(.LANES(4), .DW(16), .SW(16), .NSTAGES(4), .MODE_W(2)) dut (
        .CLK_i            (clk),
        .RST_i            (rst_n),
        .stall_i          (stall),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .stage_boundary_i (bnd),
        .operand_i        (operand),
        .scale_i          (scale),
        .norm_n_i         (norm_n),
        .pos_i            (pos),
        .mode_table_i     (mode_table),
        .out_valid_o      (out_valid),
        .operand1_o       (operand1),
        .operand2_o       (operand2),
        .stage_o          (stage),
        .mode_o           (mode),
        .finished_o       (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic add_vec(input logic [63:0] opnd, input int sc, input int n, input int p,
                           input logic b, input logic [63:0] e1, input int e2,
                           input int stg, input int md, input logic fin);
        vec_t v;
        v.opnd = opnd;  v.scale = 16'(sc); v.n = 5'(n); v.pos = 2'(p); v.bnd = b;
        v.e_op1 = e1;   v.e_op2 = 16'(e2); v.e_stg = 2'(stg); v.e_mode = 2'(md); v.e_fin = fin;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        operand  = v.opnd;
        scale    = v.scale;
        norm_n   = v.n;
        pos      = v.pos;
        bnd      = v.bnd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        bnd      = 1'b0;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, ".vld"},  64'(out_valid), 64'd1);
        chk({tag, ".op1"},  operand1,       v.e_op1);
        chk({tag, ".op2"},  64'(operand2),  64'(v.e_op2));
        chk({tag, ".stg"},  64'(stage),     64'(v.e_stg));
        chk({tag, ".mode"}, 64'(mode),      64'(v.e_mode));
        chk({tag, ".fin"},  64'(finished),  64'(v.e_fin));
    endtask

    // Back-to-back issue of the queued vectors; each must appear exactly two edges later.
    task automatic run_burst(input string tag);
        for (int i = 0; i <= vq.size(); i++) begin
            if (i < vq.size()) drive(vq[i]);
            else               idle();
            tick();
            if (i >= 1) check_out($sformatf("%s%0d", tag, i - 1), vq[i-1]);
        end
        tick();
        chk({tag, ".drain_vld"}, 64'(out_valid), 64'd0);
        vq.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".vld"},  64'(out_valid), 64'd0);
        chk({tag, ".fin"},  64'(finished),  64'd0);
        chk({tag, ".op1"},  operand1,       64'd0);
        chk({tag, ".op2"},  64'(operand2),  64'd0);
        chk({tag, ".stg"},  64'(stage),     64'd0);
        chk({tag, ".mode"}, 64'(mode),      64'd0);
    endtask

    initial begin
        vec_t p, q, r;
        rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0; bnd = 1'b0;
        operand = '0; scale = '0; norm_n = '0; pos = '0;
        mode_table = 8'h1B;  // stage0=3, stage1=2, stage2=1, stage3=0
        tick(); tick();
        check_zero("rst");
        chk("rst.ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();
        chk("idle.vld", 64'(out_valid), 64'd0);

        // Arithmetic corners; -300+1 = -299, arithmetic >>>1 floors to -150.
        add_vec(pack4(100, -100, 32767, 1), 3, 1, 1, 1'b0,
                pack4(150, -150, 32767, 2), -150, 0, 3, 1'b0);
        add_vec(pack4(-20000, 5, -5, 0), 2, 0, 0, 1'b0,
                pack4(-32768, 10, -10, 0), -32768, 0, 3, 1'b0);
        add_vec(pack4(7, -8, 24, -24), 1, 4, 3, 1'b0,
                pack4(0, 0, 2, -1), -1, 0, 3, 1'b0);
        add_vec(pack4(-32768, -32768, -32768, -32768), -32768, 31, 2, 1'b0,
                pack4(1, 1, 1, 1), 1, 0, 3, 1'b0);
        add_vec(pack4(-32768, 32767, 0, 1234), -1, 0, 0, 1'b0,
                pack4(32767, -32767, 0, -1234), 32767, 0, 3, 1'b0);
        run_burst("arith");

        // Stage tagging: boundaries on beats 2,4,6,8; ninth beat wraps to tag 0.
        for (int i = 0; i < 9; i++) begin
            add_vec(pack4(i, 0, 0, 0), 1, 0, 0, (i % 2 == 1) && (i < 8),
                    pack4(i, 0, 0, 0), i, (i < 8) ? i / 2 : 0, (i < 8) ? 3 - i / 2 : 3, i == 7);
        end
        run_burst("stg");

        // Stall with P at the output and Q in S1; R is offered but must not be taken.
        add_vec(pack4(1, 2, 3, 4), 10, 0, 2, 1'b0, pack4(10, 20, 30, 40), 30, 0, 3, 1'b0);
        add_vec(pack4(-1, -2, -3, -4), 10, 0, 3, 1'b0, pack4(-10, -20, -30, -40), -40, 0, 3, 1'b0);
        add_vec(pack4(9, 9, 9, 9), 1, 0, 0, 1'b1, pack4(9, 9, 9, 9), 9, 0, 3, 1'b0);
        p = vq[0]; q = vq[1]; r = vq[2];
        vq.delete();
        drive(p); tick();
        drive(q); tick();
        stall = 1'b1;
        drive(r);
        #1;
        chk("stall.ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("stall%0d", i), p);
        end
        stall = 1'b0;
        idle();
        tick();
        check_out("stall.q", q);
        tick();
        chk("stall.no_r", 64'(out_valid), 64'd0);
        add_vec(pack4(5, 5, 5, 5), 2, 1, 1, 1'b0, pack4(5, 5, 5, 5), 5, 0, 3, 1'b0);
        run_burst("post_stall");

        // Bring the counter to 2, then reset with two beats in flight.
        add_vec(pack4(1, 0, 0, 0), 1, 0, 0, 1'b1, pack4(1, 0, 0, 0), 1, 0, 3, 1'b0);
        add_vec(pack4(2, 0, 0, 0), 1, 0, 0, 1'b1, pack4(2, 0, 0, 0), 2, 1, 2, 1'b0);
        run_burst("pre_rst");
        add_vec(pack4(300, 300, 300, 300), 1, 0, 0, 1'b0, pack4(300, 300, 300, 300), 300, 2, 1, 1'b0);
        add_vec(pack4(400, 400, 400, 400), 1, 0, 0, 1'b0, pack4(400, 400, 400, 400), 400, 2, 1, 1'b0);
        p = vq[0]; q = vq[1];
        vq.delete();
        drive(p); tick();
        drive(q); tick();
        idle();
        check_out("inflight", p);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst%0d.vld", i), 64'(out_valid), 64'd0);
        end
        add_vec(pack4(7, 0, 0, 0), 1, 0, 0, 1'b1, pack4(7, 0, 0, 0), 7, 0, 3, 1'b0);
        add_vec(pack4(8, 0, 0, 0), 1, 0, 0, 1'b0, pack4(8, 0, 0, 0), 8, 1, 2, 1'b0);
        run_burst("rst_tag");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
